// File: rtl/seq_table_fsm_pkg.sv
// Shared widths, write-select encoding and power-up table contents for the
// table-driven sequence generator.
package seq_table_fsm_pkg;

    localparam int DEF_STATE_W = 3;
    localparam int DEF_IN_W    = 1;
    localparam int DEF_OUT_W   = 3;

    typedef enum logic {
        WR_SEL_NXT = 1'b0,
        WR_SEL_OTB = 1'b1
    } wr_sel_e;

    function automatic int addr_w(input int state_w, input int in_w);
        return state_w + in_w;
    endfunction

    function automatic int data_w(input int state_w, input int out_w);
        return (state_w > out_w) ? state_w : out_w;
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_STATE_W, DEF_IN_W);
    localparam int DEF_DATA_W = data_w(DEF_STATE_W, DEF_OUT_W);

    // Power-up NXT entry: every branch of state s goes to s+1, wrapping.
    function automatic int unsigned nxt_default(input int unsigned addr,
                                                input int unsigned in_w,
                                                input int unsigned state_w);
        return ((addr >> in_w) + 32'd1) & ((32'd1 << state_w) - 32'd1);
    endfunction

    // Power-up OTB entry: output word equals the state number.
    function automatic int unsigned otb_default(input int unsigned s,
                                                input int unsigned out_w);
        return (out_w >= 32) ? s : (s & ((32'd1 << out_w) - 32'd1));
    endfunction

endpackage

// File: rtl/seq_table_fsm_mem.sv
// Next-state and output tables: reset to a binary counter, single write port,
// two combinational read ports addressed by the live state.
module seq_table_fsm_mem
    import seq_table_fsm_pkg::*;
#(
    parameter  int STATE_W = DEF_STATE_W,
    parameter  int IN_W    = DEF_IN_W,
    parameter  int OUT_W   = DEF_OUT_W,
    localparam int ADDR_W  = addr_w(STATE_W, IN_W),
    localparam int DATA_W  = data_w(STATE_W, OUT_W)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               wr_en_i,
    input  logic               wr_sel_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic [STATE_W-1:0] rd_state_i,
    input  logic [IN_W-1:0]    rd_a_i,
    output logic [STATE_W-1:0] rd_nxt_o,
    output logic [OUT_W-1:0]   rd_out_o
);

    localparam int NXT_N = 1 << ADDR_W;
    localparam int OTB_N = 1 << STATE_W;

    logic [STATE_W-1:0] nxt_q [NXT_N];
    logic [OUT_W-1:0]   otb_q [OTB_N];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < NXT_N; i++) begin
                nxt_q[i] <= STATE_W'(nxt_default(i, IN_W, STATE_W));
            end
            for (int i = 0; i < OTB_N; i++) begin
                otb_q[i] <= OUT_W'(otb_default(i, OUT_W));
            end
        end else if (wr_en_i) begin
            if (wr_sel_i == WR_SEL_NXT) begin
                nxt_q[wr_addr_i] <= wr_data_i[STATE_W-1:0];
            end else begin
                // Output table is indexed by state only; the branch bits are ignored.
                otb_q[wr_addr_i[ADDR_W-1:IN_W]] <= wr_data_i[OUT_W-1:0];
            end
        end
    end

    assign rd_nxt_o = nxt_q[{rd_state_i, rd_a_i}];
    assign rd_out_o = otb_q[rd_state_i];

endmodule

// File: rtl/seq_table_fsm.sv
// Table-driven Moore sequence generator: state register, clr/en priority and
// wrap flag; the transition and output functions live in seq_table_fsm_mem.
//   state | meaning
//   START | reset / clr target; entering it by a transition raises wrap
//   other | meaning defined by the programmed tables
module seq_table_fsm
    import seq_table_fsm_pkg::*;
#(
    parameter  int STATE_W = DEF_STATE_W,
    parameter  int IN_W    = DEF_IN_W,
    parameter  int OUT_W   = DEF_OUT_W,
    parameter  int START   = 0,
    localparam int ADDR_W  = addr_w(STATE_W, IN_W),
    localparam int DATA_W  = data_w(STATE_W, OUT_W)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic               clr,
    input  logic [IN_W-1:0]    a,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [OUT_W-1:0]   out,
    output logic [STATE_W-1:0] state,
    output logic               wrap
);

    localparam logic [STATE_W-1:0] START_S = STATE_W'(START);

    logic [STATE_W-1:0] state_q, state_d;
    logic               wrap_q, wrap_d;
    logic [STATE_W-1:0] nxt_state;
    logic [OUT_W-1:0]   out_word;

    seq_table_fsm_mem #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_mem (
        .clk        (clk),
        .res        (res),
        .wr_en_i    (wr_en),
        .wr_sel_i   (wr_sel),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_state_i (state_q),
        .rd_a_i     (a),
        .rd_nxt_o   (nxt_state),
        .rd_out_o   (out_word)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= START_S;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    // nxt_state is read before any same-edge table write lands.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (clr) begin
            state_d = START_S;
        end else if (en) begin
            state_d = nxt_state;
            wrap_d  = (nxt_state == START_S);
        end
    end

    assign state = state_q;
    assign wrap  = wrap_q;
    assign out   = out_word;

endmodule

// File: tb/tb_seq_table_fsm.sv
// Bench for seq_table_fsm: table of per-cycle vectors with expected state/out/wrap,
// queued on drive and compared after the edge, plus a hand-written async reset.
module tb_seq_table_fsm;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic       clr;
    logic [0:0] a;
    logic       wr_en;
    logic       wr_sel;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic [2:0] out;
    logic [2:0] state;
    logic       wrap;

    int n_chk  = 0;
    int n_fail = 0;

    seq_table_fsm dut (
        .clk     (clk),
        .res     (res),
        .en      (en),
        .clr     (clr),
        .a       (a),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .out     (out),
        .state   (state),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       a;
        logic       wr_en;
        logic       wr_sel;
        logic [3:0] addr;
        logic [2:0] data;
        logic [2:0] s;
        logic [2:0] o;
        logic       w;
        string      name;
    } vec_t;

    typedef struct {
        logic [2:0] s;
        logic [2:0] o;
        logic       w;
        string      name;
    } exp_t;

    vec_t tab1[$];
    vec_t tab2[$];
    exp_t sb[$];

    task automatic add(inout vec_t q[$], input logic e, input logic c, input logic ai,
                       input logic we, input logic ws, input logic [3:0] ad,
                       input logic [2:0] d, input logic [2:0] s, input logic [2:0] o,
                       input logic w, input string nm);
        vec_t v;
        v.en = e; v.clr = c; v.a = ai; v.wr_en = we; v.wr_sel = ws;
        v.addr = ad; v.data = d; v.s = s; v.o = o; v.w = w; v.name = nm;
        q.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] s, input logic [2:0] o,
                         input logic w);
        n_chk++;
        if (state !== s) begin
            n_fail++;
            $display("FAIL %s state: got %0d, expected %0d", nm, state, s);
        end
        n_chk++;
        if (out !== o) begin
            n_fail++;
            $display("FAIL %s out: got %0d, expected %0d", nm, out, o);
        end
        n_chk++;
        if (wrap !== w) begin
            n_fail++;
            $display("FAIL %s wrap: got %0b, expected %0b", nm, wrap, w);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        en = v.en; clr = v.clr; a = v.a; wr_en = v.wr_en; wr_sel = v.wr_sel;
        wr_addr = v.addr; wr_data = v.data;
        sb.push_back('{v.s, v.o, v.w, v.name});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.s, e.o, e.w);
    endtask

    task automatic build_tables();
        logic [2:0] cnt;
        // Power-up counting: 1..7, 0 (wrap), 1, 2
        for (int i = 1; i <= 10; i++) begin
            cnt = 3'(i);
            add(tab1, 1, 0, 0, 0, 0, 0, 0, cnt, cnt, (i == 8), "default_count");
        end
        // Program tables with en=0: state held at 2, OTB[2] stays 2
        add(tab1, 0, 0, 0, 1, 1, 4'd0, 3'd0, 2, 2, 0, "wr_otb0");
        add(tab1, 0, 0, 0, 1, 1, 4'd2, 3'd3, 2, 2, 0, "wr_otb1");
        add(tab1, 0, 0, 0, 1, 1, 4'd4, 3'd2, 2, 2, 0, "wr_otb2");
        add(tab1, 0, 0, 0, 1, 1, 4'd6, 3'd4, 2, 2, 0, "wr_otb3");
        add(tab1, 0, 0, 0, 1, 1, 4'd8, 3'd5, 2, 2, 0, "wr_otb4");
        add(tab1, 0, 0, 0, 1, 0, 4'd0, 3'd1, 2, 2, 0, "wr_nxt00");
        add(tab1, 0, 0, 0, 1, 0, 4'd1, 3'd1, 2, 2, 0, "wr_nxt01");
        add(tab1, 0, 0, 0, 1, 0, 4'd2, 3'd2, 2, 2, 0, "wr_nxt10");
        add(tab1, 0, 0, 0, 1, 0, 4'd3, 3'd4, 2, 2, 0, "wr_nxt11");
        add(tab1, 0, 0, 0, 1, 0, 4'd4, 3'd3, 2, 2, 0, "wr_nxt20");
        add(tab1, 0, 0, 0, 1, 0, 4'd5, 3'd3, 2, 2, 0, "wr_nxt21");
        add(tab1, 0, 0, 0, 1, 0, 4'd6, 3'd0, 2, 2, 0, "wr_nxt30");
        add(tab1, 0, 0, 0, 1, 0, 4'd7, 3'd1, 2, 2, 0, "wr_nxt31");
        add(tab1, 0, 0, 0, 1, 0, 4'd8, 3'd2, 2, 2, 0, "wr_nxt40");
        add(tab1, 0, 0, 0, 1, 0, 4'd9, 3'd2, 2, 2, 0, "wr_nxt41");
        add(tab1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr0");
        // Branch a=0: out 3,2,4,0,3
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, "a0_s1");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0, "a0_s2");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 3, 4, 0, "a0_s3");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "a0_s0_wrap");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, "a0_s1b");
        add(tab1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr1");
        // Branch a=1: out 3,5,2,4,3,5, no wrap on 3->1
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 1, 3, 0, "a1_s1");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 4, 5, 0, "a1_s4");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 2, 2, 0, "a1_s2");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 3, 4, 0, "a1_s3");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 1, 3, 0, "a1_s1b");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 4, 5, 0, "a1_s4b");
        // Hold mid-sequence at 4, then right after a wrap at 0
        add(tab1, 0, 0, 1, 0, 0, 0, 0, 4, 5, 0, "hold4_a");
        add(tab1, 0, 0, 0, 0, 0, 0, 0, 4, 5, 0, "hold4_b");
        add(tab1, 0, 0, 1, 0, 0, 0, 0, 4, 5, 0, "hold4_c");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 2, 2, 0, "resume_s2");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 3, 4, 0, "run_s3");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "run_s0_wrap");
        add(tab1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "hold0_a");
        add(tab1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "hold0_b");
        add(tab1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "hold0_c");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, "resume_s1");
        // clr beats en, even when NXT would have wrapped to START
        add(tab1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr_en_from1");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, "ce_s1");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0, "ce_s2");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 3, 4, 0, "ce_s3");
        add(tab1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr_en_from3_nowrap");
        // Rewrite NXT[{0,0}]=5 on the transition edge: old target 1 taken
        add(tab1, 1, 0, 0, 1, 0, 4'd0, 3'd5, 1, 3, 0, "wr_same_edge");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0, "we_s2");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 3, 4, 0, "we_s3");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "we_s0_wrap");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 5, 5, 0, "new_target_s5");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 6, 6, 0, "default_s6");
        // OTB[state] write shows on out after the write edge
        add(tab1, 0, 0, 0, 1, 1, 4'd12, 3'd1, 6, 1, 0, "wr_otb_cur");
        // START self-loop on a=1 keeps wrap high
        add(tab1, 0, 0, 0, 1, 0, 4'd1, 3'd0, 6, 1, 0, "wr_selfloop");
        add(tab1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "clr2");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "selfloop_a");
        add(tab1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, "selfloop_b");
        add(tab1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "selfloop_hold");
        add(tab1, 1, 0, 0, 0, 0, 0, 0, 5, 5, 0, "pre_reset_s5");
        // After reset release: default counting again, wrap on 7->0
        for (int i = 1; i <= 8; i++) begin
            cnt = 3'(i);
            add(tab2, 1, 0, 0, 0, 0, 0, 0, cnt, cnt, (i == 8), "post_reset_count");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b0; en = 1'b0; clr = 1'b0; a = '0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        build_tables();
        #12;
        check("reset", 3'd0, 3'd0, 1'b0);
        res = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_hold", 3'd0, 3'd0, 1'b0);

        for (int i = 0; i < tab1.size(); i++) apply(tab1[i]);

        // Async reset mid-run with programmed contents
        en = 1'b0; wr_en = 1'b0; clr = 1'b0; a = '0;
        #2;
        res = 1'b0;
        #1;
        check("async_reset", 3'd0, 3'd0, 1'b0);
        #2;
        res = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", 3'd0, 3'd0, 1'b0);

        for (int i = 0; i < tab2.size(); i++) apply(tab2[i]);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
